reg_file: RTL
=============

# reg_file

Architectural register file for the single-cycle core, sitting directly downstream of the destination-register select mux: it consumes the selected 5-bit `WriteReg` address plus write-back data, and supplies the two source operands to the ALU stage. It is 32 entries deep, with two asynchronous read ports and one synchronous write port. Register 0 is hardwired to zero. After every reset a sequencer sweeps all entries to zero before the file reports `ready`.

## Interface

Parameters:
- `WIDTH`, 32, data width of every register and data port.
- `BYPASS`, 1, when 1 a same-cycle write is forwarded to a matching read port; when 0 the read returns the stored (old) value.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `RegWrite`  input  1  write enable from control.
- `WriteReg`  input  5  destination address from the register-destination mux.
- `WriteData`  input  WIDTH  write-back value.
- `ReadReg1`  input  5  source address 1 (instruction bits 25:21).
- `ReadReg2`  input  5  source address 2 (instruction bits 20:16).
- `ReadData1`  output  WIDTH  operand 1, combinational.
- `ReadData2`  output  WIDTH  operand 2, combinational.
- `ready`  output  1  registered; high once the post-reset clear sweep has completed.

## Operation

- **Storage.** 32 × WIDTH array; entry 0 is never written and always reads 0.
- **States.** Two-state sequencer, `CLEAR` and `RUN`, with a 5-bit clear pointer `clr_ptr`.
- **Reset.** On any edge with `rst`=1:
  - state becomes `CLEAR`, `clr_ptr` = 0, `ready` = 0.
  - The array is not modified on that edge.
  - This holds regardless of current state; reset during a sweep restarts the sweep from entry 0.
- **CLEAR state** (`rst`=0):
  - Each edge writes 0 to entry `clr_ptr`, then increments `clr_ptr`.
  - On the edge that clears entry 31, state becomes `RUN` and `ready` becomes 1.
  - `RegWrite` is ignored (no write, no bypass).
  - `ReadData1` and `ReadData2` are forced to 0.
- **RUN state writes.** On each edge with `RegWrite`=1 and `WriteReg`≠0, entry `WriteReg` takes `WriteData`. A write with `WriteReg`=0 is discarded.
- **Reads.**
  - `ReadDataN` = 0 if `ReadRegN`=0.
  - Otherwise, if `BYPASS`=1, `RegWrite`=1, state=`RUN` and `WriteReg`=`ReadRegN`, then `ReadDataN` = `WriteData`.
  - Otherwise `ReadDataN` = the stored entry `ReadRegN`.
- Both read ports may address the same entry; each evaluates independently.
- No arithmetic beyond the 5-bit pointer increment. The increment never wraps in use, because the sweep ends at 31.

## Timing

- **Read latency.** 0 cycles (combinational from addresses, array contents, and bypass inputs).
- **Write latency.** A value written on edge N is visible through the array from just after edge N. With `BYPASS`=1 it is also visible in the cycle before edge N.
- **Reset values.**
  - `ready` = 0.
  - `ReadData1` and `ReadData2` = 0 while in `CLEAR`.
  - Array contents are unspecified until swept.
- **Sweep length.**
  - `ready` rises on the 32nd rising edge after the first edge sampling `rst`=0.
  - Holding `rst` high for any number of cycles leaves `clr_ptr` at 0.
- **Simultaneous events.**
  - `rst`=1 with `RegWrite`=1: reset wins and no write occurs.
  - Write and read to the same address in `RUN`: the bypass rule above applies.

## Test plan

- **Reset sweep.** Preload garbage via RUN writes, then pulse `rst` for 1 cycle.
  - `ready`=0 for exactly 32 edges and rises on edge 32.
  - Afterwards every address 1–31 reads 0x00000000.
- **Basic write/read.** In RUN, write 0xDEADBEEF to r5 and 0x12345678 to r31.
  - `ReadReg1`=5 reads 0xDEADBEEF.
  - `ReadReg2`=31 reads 0x12345678.
  - r4 is still 0.
- **r0 hardwired.** Write 0xFFFFFFFF to `WriteReg`=0.
  - Both ports reading r0 give 0, both during the write cycle and after it.
- **Bypass.** Set `BYPASS`=1 with r7=0x11111111. In one cycle drive `RegWrite`=1, `WriteReg`=7, `WriteData`=0x22222222, `ReadReg1`=`ReadReg2`=7.
  - Both ports read 0x22222222 in that cycle.
  - Repeat with `BYPASS`=0: both ports read 0x11111111 in that cycle and 0x22222222 after the edge.
- **Reset mid-sweep.**
  - Assert `rst` at sweep edge 10 with `RegWrite`=1 to r3: no write occurs, and `clr_ptr` restarts.
  - `ready` rises 32 edges after `rst` falls.
- **Writes during CLEAR.** Drive `RegWrite`=1, `WriteReg`=9, `WriteData`=0xAAAA5555 on every sweep cycle.
  - Both read ports read 0 throughout.
  - r9 reads 0 once `ready`=1.

Source files
------------

// File: rtl/reg_file.sv
// 32-entry register file, 2 async read ports, 1 sync write port, r0 reads zero; post-reset sweep clears all entries.
// Reads are 0-cycle, writes land on the edge; no backpressure, but writes and reads are inert until ready.
module reg_file #(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWrite,
    input  logic [4:0]       WriteReg,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadReg1,
    input  logic [4:0]       ReadReg2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state, state_nxt;
    logic [4:0]       clr_ptr, clr_ptr_nxt;
    logic             ready_nxt;
    logic [WIDTH-1:0] mem [32];
    logic             run_wr;

    always_ff @(posedge clk) begin
        state   <= state_nxt;
        clr_ptr <= clr_ptr_nxt;
        ready   <= ready_nxt;
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        ready_nxt   = ready;
        if (rst) begin
            state_nxt   = CLEAR;
            clr_ptr_nxt = 5'd0;
            ready_nxt   = 1'b0;
        end else if (state == CLEAR) begin
            clr_ptr_nxt = clr_ptr + 5'd1;
            if (clr_ptr == 5'd31) begin
                state_nxt = RUN;
                ready_nxt = 1'b1;
            end
        end
    end

    // Write enable ignores rst so the bypass path stays purely state-based.
    assign run_wr = (state == RUN) && RegWrite;

    // The array is left untouched on reset edges; the sweep does the clearing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (run_wr && (WriteReg != 5'd0)) begin
                mem[WriteReg] <= WriteData;
            end
        end
    end

    always_comb begin
        ReadData1 = '0;
        if ((ReadReg1 != 5'd0) && (state == RUN)) begin
            if (BYPASS && run_wr && (WriteReg == ReadReg1)) begin
                ReadData1 = WriteData;
            end else begin
                ReadData1 = mem[ReadReg1];
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        if ((ReadReg2 != 5'd0) && (state == RUN)) begin
            if (BYPASS && run_wr && (WriteReg == ReadReg2)) begin
                ReadData2 = WriteData;
            end else begin
                ReadData2 = mem[ReadReg2];
            end
        end
    end

endmodule
